// File: rtl/wf_seq_pkg.sv
// Shared definitions for the waterfall configuration sequencer: FSM states,
// command step order, sampler control bit positions and decimation limit.
package wf_seq_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, GAPW, DONE} wf_state_t;

  // Order in which the four configuration commands are issued.
  typedef enum logic [1:0] {FREQH, FREQL, DECIM, RST} wf_step_t;

  localparam int WF_SAMP_WR_RST = 0;
  localparam int WF_SAMP_CONTIN = 1;
  localparam int WF_1CIC_MAXD   = 4096;

  function automatic wf_step_t next_step(input wf_step_t s);
    return wf_step_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/wf_seq_gap_timer.sv
// Idle-gap countdown between command strobes: load arms GAP cycles,
// expire pulses high during the last of them.
module wf_seq_gap_timer #(
  parameter int GAP = 4,
  parameter int GW  = (GAP > 0) ? $clog2(GAP + 1) : 1
) (
  input  logic cpu_clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  output logic expire
);

  logic [GW-1:0] cnt_q;

  always_ff @(posedge cpu_clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= GW'(GAP);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - GW'(1);
    end
  end

  assign expire = (cnt_q == GW'(1));

endmodule

// File: rtl/wf_cfg_seq.sv
// Waterfall channel configuration sequencer: issues freqH, freqL, decim and
// sampler-reset strobes to one channel, each followed by GAP idle cycles.
module wf_cfg_seq
  import wf_seq_pkg::*;
#(
  parameter int NWF  = 4,
  parameter int GAP  = 4,
  parameter int MD   = 16,
  parameter int MAXD = WF_1CIC_MAXD,
  localparam int CW  = (NWF > 1) ? $clog2(NWF) : 1
) (
  input  logic           cpu_clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [CW-1:0]  req_ch,
  input  logic [47:0]    req_freq,
  input  logic [MD-1:0]  req_decim,
  input  logic           req_contin,
  input  logic           abort,
  output logic [NWF-1:0] wf_sel_C,
  output logic           set_wf_freqH_C,
  output logic           set_wf_freqL_C,
  output logic           set_wf_decim_C,
  output logic           rst_wf_sampler_C,
  output logic [31:0]    freeze_tos,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           err
);

  wf_state_t      state_q, state_n;
  wf_step_t       step_q, step_n;
  logic [CW-1:0]  ch_q;
  logic [47:0]    freq_q;
  logic [MD-1:0]  decim_q;
  logic           contin_q;
  logic           err_q, aborted_q;
  logic           timer_load, gap_expire;

  logic           accept, ch_bad, decim_big, run_abort;
  logic [MD-1:0]  decim_fix;
  logic [31:0]    word;

  assign accept    = req_valid && (state_q == IDLE);
  assign ch_bad    = 32'(req_ch) >= NWF;
  assign decim_big = 32'(req_decim) > MAXD;
  assign run_abort = abort && (state_q != IDLE);
  assign decim_fix = (req_decim == '0) ? MD'(1) :
                     decim_big         ? MD'(MAXD) : req_decim;

  wf_seq_gap_timer #(.GAP(GAP)) u_gap (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .clr     (run_abort),
    .load    (timer_load),
    .expire  (gap_expire)
  );

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= FREQH;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      ch_q      <= '0;
      freq_q    <= '0;
      decim_q   <= '0;
      contin_q  <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      err_q     <= accept && (ch_bad || decim_big);
      aborted_q <= run_abort;
      if (accept && !ch_bad) begin
        ch_q     <= req_ch;
        freq_q   <= req_freq;
        decim_q  <= decim_fix;
        contin_q <= req_contin;
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    step_n     = step_q;
    timer_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !ch_bad) begin
          state_n = STROBE;
          step_n  = FREQH;
        end
      end
      STROBE: begin
        timer_load = 1'b1;
        // A zero gap chains strobes back to back without visiting GAPW.
        if (GAP == 0) begin
          if (step_q == RST) state_n = DONE;
          else               step_n  = next_step(step_q);
        end else begin
          state_n = GAPW;
        end
      end
      GAPW: begin
        if (gap_expire) begin
          if (step_q == RST) begin
            state_n = DONE;
          end else begin
            state_n = STROBE;
            step_n  = next_step(step_q);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (run_abort) begin
      state_n = IDLE;
      step_n  = FREQH;
    end
  end

  always_comb begin
    word = '0;
    unique case (step_q)
      FREQH: word = freq_q[47:16];
      FREQL: word = {16'b0, freq_q[15:0]};
      DECIM: word = 32'(decim_q);
      RST: begin
        word[WF_SAMP_WR_RST] = 1'b1;
        word[WF_SAMP_CONTIN] = contin_q;
      end
      default: word = '0;
    endcase
  end

  always_comb begin
    set_wf_freqH_C   = 1'b0;
    set_wf_freqL_C   = 1'b0;
    set_wf_decim_C   = 1'b0;
    rst_wf_sampler_C = 1'b0;
    wf_sel_C         = '0;
    freeze_tos       = '0;
    if (state_q == STROBE) begin
      set_wf_freqH_C   = (step_q == FREQH);
      set_wf_freqL_C   = (step_q == FREQL);
      set_wf_decim_C   = (step_q == DECIM);
      rst_wf_sampler_C = (step_q == RST);
    end
    // Select and data word stay put across each strobe and its gap.
    if (state_q == STROBE || state_q == GAPW) begin
      wf_sel_C   = NWF'(1) << ch_q;
      freeze_tos = word;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign done      = (state_q == DONE) && !abort;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule

// File: doc/wf_cfg_seq.md
WF_CFG_SEQ -- requirements
Module: wf_cfg_seq

Interface
REQ-001 SHALL have parameter NWF, default 4: number of waterfall channels addressed.
REQ-002 SHALL have parameter GAP, default 4: idle cpu_clk cycles after each strobe, giving SYNC_PULSE crossing margin.
REQ-003 SHALL have parameter MD, default 16: decimation field width.
REQ-004 SHALL have parameter MAXD, default WF_1CIC_MAXD: largest legal decimation.
REQ-005 SHALL have port cpu_clk, in, 1: sole clock.
REQ-006 SHALL have port reset, in, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, in, 1: configuration request present.
REQ-008 SHALL have port req_ready, out, 1: request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_ch, in, clog2(NWF): target channel.
REQ-010 SHALL have port req_freq, in, 48: phase increment.
REQ-011 SHALL have port req_decim, in, MD: CIC decimation.
REQ-012 SHALL have port req_contin, in, 1: continuous-sampler mode.
REQ-013 SHALL have port abort, in, 1: cancel the sequence in progress.
REQ-014 SHALL have port wf_sel_C, out, NWF: one-hot channel select.
REQ-015 SHALL have ports set_wf_freqH_C, set_wf_freqL_C, set_wf_decim_C and rst_wf_sampler_C, out, 1 each: command strobes.
REQ-016 SHALL have port freeze_tos, out, 32: data word accompanying the strobes.
REQ-017 SHALL have ports busy, done, aborted and err, out, 1 each: status; done, aborted and err are one-cycle pulses.

Function
REQ-018 SHALL use the states IDLE, STROBE, GAPW and DONE, with step counter s = 0..3 ordered FREQH, FREQL, DECIM, RST.
REQ-019 SHALL drive req_ready = (state==IDLE); busy = !req_ready.
REQ-020 SHALL, on acceptance at cycle T, latch all req_* fields, enter STROBE with s=0 at T+1, and ignore further req_valid until IDLE.
REQ-021 SHALL, in STROBE, assert exactly one strobe for one cycle: s=0 freqH, s=1 freqL, s=2 decim, s=3 rst_wf_sampler.
REQ-022 SHALL assert wf_sel_C = 1<<ch from the first strobe through the last GAPW cycle, and drive it all-zero otherwise.
REQ-023 SHALL set freeze_tos to: freq[47:16] at s=0; {16'b0, freq[15:0]} at s=1; zero-extended decim at s=2; at s=3, bit WF_SAMP_WR_RST=1, bit WF_SAMP_CONTIN=contin, all other bits 0.
REQ-024 SHALL hold freeze_tos stable from each strobe through the end of the GAP cycles that follow it.
REQ-025 SHALL, after STROBE, spend exactly GAP cycles in GAPW, then go to STROBE with s+1, or to DONE when s==3.
REQ-026 SHALL place strobe k at T+1+k*(GAP+1), pulse done at T+1+4*(GAP+1), and be back in IDLE one cycle after done.
REQ-027 SHALL replace req_decim==0 by 1, clamp req_decim>MAXD to MAXD, and pulse err at T+1 on clamping; the sequence still runs.
REQ-028 SHALL reject req_ch>=NWF at acceptance: err pulse at T+1, no strobes, remain IDLE.
REQ-029 SHALL, on abort in STROBE, GAPW or DONE: go to IDLE the next cycle, drop all strobes and wf_sel_C, pulse aborted, and suppress done; a strobe already high in that cycle completes.
REQ-030 SHALL ignore abort in IDLE, and SHALL give abort priority when abort coincides with the DONE cycle (aborted pulses, done suppressed).
REQ-031 SHALL never assert two strobes in the same cycle.

Reset
REQ-032 SHALL, while reset is high at a cpu_clk edge, go to IDLE with s=0, all strobes 0, wf_sel_C 0, freeze_tos 0, done/aborted/err 0 and latched fields 0.
REQ-033 SHALL, on reset mid-sequence, emit no further strobes and no done or aborted pulse.

Structure
REQ-034 SHALL place the state enum, step encoding, WF_SAMP_WR_RST/WF_SAMP_CONTIN bit indices and WF_1CIC_MAXD in shared package wf_seq_pkg.
REQ-035 SHALL implement the GAP countdown in one sub-module, wf_seq_gap_timer (load, count, expire pulse).

Verification
REQ-036 SHALL test, with GAP=4: request ch=2, freq=0x0123_4567_89AB, decim=256, contin=1, accepted at T -> wf_sel_C=4'b0100; freqH at T+1 with 0x01234567; freqL at T+6 with 0x000089AB; decim at T+11 with 0x100; rst at T+16; done at T+21; ready at T+22.
REQ-037 SHALL test decim=0 -> decim strobe carries 1, no err; decim=MAXD+5 -> freeze_tos=MAXD, err at T+1.
REQ-038 SHALL test ch=NWF -> err at T+1, no strobes, req_ready stays 1.
REQ-039 SHALL test abort at T+8 -> aborted at T+9, no decim or rst strobe, no done, req_ready=1 at T+9.
REQ-040 SHALL test reset at T+12 -> all outputs 0 at T+13, no further strobes, and a new request accepted normally afterwards.
REQ-041 SHALL test back-to-back requests with req_valid held high -> the second is accepted at T+22 and exactly 8 strobes occur, never overlapping.
